// File: rtl/attn_mask_scale_stream.sv
// Streams a TQ x TK Y tile through mask/scale into a credit-guarded FIFO.
// Optional ATTN_MASK_STATS_EN enables masked_cnt; ports per block header.
module attn_mask_scale_stream #(
  parameter int TQ         = 8,
  parameter int TK         = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_W    = 3,
  localparam int TQ_W  = (TQ > 1) ? $clog2(TQ) : 1,
  localparam int TK_W  = (TK > 1) ? $clog2(TK) : 1,
  localparam int CNT_W = TQ_W + TK_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mask_mode,
  input  logic [TQ-1:0]      pad_valid_q,
  input  logic [TK-1:0]      pad_valid_k,
  input  logic [TK_W:0]      win_len,
  input  logic [SHIFT_W-1:0] scale_shift,
  output logic               busy,
  output logic               done,
  output logic               y_re,
  output logic [TQ_W-1:0]    y_tq,
  output logic [TK_W-1:0]    y_tk,
  input  logic [31:0]        y_rdata,
  input  logic               y_rvalid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [TQ_W-1:0]    out_row,
  output logic [TK_W-1:0]    out_col,
  output logic               out_last_col,
  output logic               out_last,
  output logic [CNT_W-1:0]   masked_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE
  } state_t;

  typedef struct packed {
    logic [31:0]     data;
    logic [TQ_W-1:0] row;
    logic [TK_W-1:0] col;
    logic            last_col;
    logic            last;
  } beat_t;

  state_t             state;
  logic [TQ_W-1:0]    rr;
  logic [TK_W-1:0]    cc;
  logic [1:0]         cfg_mode;
  logic [TQ-1:0]      cfg_pq;
  logic [TK-1:0]      cfg_pk;
  logic [TK_W:0]      cfg_win;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               in_flight;
  logic [TQ_W-1:0]    tag_r;
  logic [TK_W-1:0]    tag_c;
  beat_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [OCC_W-1:0]   occ;

  logic  credit_ok;
  logic  wr;
  logic  rd;
  logic  m;
  logic  last_rc;
  beat_t wbeat;

  // One request outstanding at most; a late y_rvalid holds issue.
  assign credit_ok = (32'(occ) + 32'(in_flight))
                     < 32'(FIFO_DEPTH);
  assign y_re = (state == ST_ISSUE) & credit_ok
              & ~(in_flight & ~y_rvalid);
  assign wr   = y_rvalid & in_flight;
  assign rd   = out_valid & out_ready;
  assign y_tq = rr;
  assign y_tk = cc;
  assign busy = (state == ST_ISSUE) | (state == ST_DRAIN);
  assign done = (state == ST_DONE);
  assign last_rc = (rr == TQ_W'(TQ - 1))
                 & (cc == TK_W'(TK - 1));

  always_comb begin
    logic [31:0] r32;
    logic [31:0] c32;
    logic        pad_m;
    logic        cau_m;
    logic        win_m;
    logic [7:0]  e;
    logic [7:0]  sh;
    r32   = 32'(tag_r);
    c32   = 32'(tag_c);
    pad_m = ~cfg_pq[tag_r] | ~cfg_pk[tag_c];
    cau_m = c32 > r32;
    win_m = (cfg_win != '0) & (r32 >= c32)
          & ((r32 - c32) >= 32'(cfg_win));
    m = 1'b0;
    unique case (1'b1)
      (cfg_mode == 2'd0): m = 1'b0;
      (cfg_mode == 2'd1): m = pad_m;
      (cfg_mode == 2'd2): m = pad_m | cau_m;
      default:            m = pad_m | cau_m | win_m;
    endcase
    e  = y_rdata[30:23];
    sh = 8'(cfg_shift);
    wbeat.row      = tag_r;
    wbeat.col      = tag_c;
    wbeat.last_col = (tag_c == TK_W'(TK - 1));
    wbeat.last     = wbeat.last_col
                   & (tag_r == TQ_W'(TQ - 1));
    if (m)
      wbeat.data = 32'hFF80_0000;
    else if (e == 8'h00 || e == 8'hFF)
      wbeat.data = y_rdata;
    else if (e <= sh)
      wbeat.data = {y_rdata[31], 31'b0};
    else
      wbeat.data = {y_rdata[31], e - sh, y_rdata[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr        <= '0;
      cc        <= '0;
      cfg_mode  <= '0;
      cfg_pq    <= '0;
      cfg_pk    <= '0;
      cfg_win   <= '0;
      cfg_shift <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          cfg_mode  <= mask_mode;
          cfg_pq    <= pad_valid_q;
          cfg_pk    <= pad_valid_k;
          cfg_win   <= win_len;
          cfg_shift <= scale_shift;
          rr        <= '0;
          cc        <= '0;
          state     <= ST_ISSUE;
        end
        ST_ISSUE: if (y_re) begin
          if (last_rc) begin
            state <= ST_DRAIN;
          end else if (cc == TK_W'(TK - 1)) begin
            cc <= '0;
            rr <= rr + TQ_W'(1);
          end else begin
            cc <= cc + TK_W'(1);
          end
        end
        ST_DRAIN: if (rd & out_last) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= 1'b0;
      tag_r     <= '0;
      tag_c     <= '0;
    end else begin
      in_flight <= y_re | (in_flight & ~y_rvalid);
      if (y_re) begin
        tag_r <= rr;
        tag_c <= cc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= wbeat;
        wptr      <= wptr + PTR_W'(1);
      end
      if (rd) rptr <= rptr + PTR_W'(1);
      occ <= occ + OCC_W'(wr) - OCC_W'(rd);
    end
  end

  assign out_valid    = (occ != '0);
  assign out_data     = mem[rptr].data;
  assign out_row      = mem[rptr].row;
  assign out_col      = mem[rptr].col;
  assign out_last_col = mem[rptr].last_col;
  assign out_last     = mem[rptr].last;

`ifdef ATTN_MASK_STATS_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (state == ST_IDLE && start)
      cnt <= '0;
    else if (wr & m)
      cnt <= cnt + CNT_W'(1);
  end
  assign masked_cnt = cnt;
`else
  assign masked_cnt = '0;
`endif

endmodule
